// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that shares one valid/ready byte-stream sink among NUM_REQ packet sources.
// A grant is held until the packet's last beat is accepted, or force-released after MAX_BEATS beats.
module stream_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BEATS  = 16,
   localparam int IDW       = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            out_valid,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic                            out_last,
   input  logic                            out_ready,
   output logic [IDW-1:0]                  grant_id,
   output logic                            busy,
   output logic                            overrun,
   output logic [15:0]                     pkt_count
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [7:0]     beats_q, beats_d;
   logic [15:0]    pkt_q, pkt_d;
   logic           overrun_q, overrun_d;

   logic [IDW-1:0] sel;
   logic           found;
   logic           accept;
   logic           forced;

   // Rotating priority search: first asserted request at or after ptr, wrapping.
   always_comb begin
      int idx;
      logic [IDW-1:0] cand;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx  = (int'(ptr_q) + i) % NUM_REQ;
         cand = idx[IDW-1:0];
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      if (state_q == LOCK) begin
         out_valid          = req_valid[grant_q];
         out_data           = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
         out_last           = req_last[grant_q];
         req_ready[grant_q] = out_ready;
      end
   end

   assign accept = out_valid && out_ready;
   assign forced = accept && !req_last[grant_q] && (beats_q == 8'(MAX_BEATS - 1));

   // A forced release is a normal release that skips the last flag and flags overrun.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      beats_d   = beats_q;
      pkt_d     = pkt_q;
      overrun_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = sel;
               beats_d = '0;
               state_d = LOCK;
            end
         end
         LOCK: begin
            if (accept) begin
               beats_d = beats_q + 8'd1;
               if (req_last[grant_q] || forced) begin
                  state_d   = IDLE;
                  ptr_d     = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                  pkt_d     = pkt_q + 16'd1;
                  overrun_d = forced;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         beats_q   <= '0;
         pkt_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         beats_q   <= beats_d;
         pkt_q     <= pkt_d;
         overrun_q <= overrun_d;
      end
   end

   assign grant_id  = grant_q;
   assign busy      = (state_q == LOCK);
   assign overrun   = overrun_q;
   assign pkt_count = pkt_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: per-requester source queues drive packets,
// expected beats are queued by the stimulus and popped by a monitor on every accepted beat.
module tb_stream_rr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;

   logic               clk;
   logic               reset_n;
   logic [NR-1:0]      req_valid;
   logic [NR*DW-1:0]   req_data;
   logic [NR-1:0]      req_last;
   logic [NR-1:0]      req_ready;
   logic               out_valid;
   logic [DW-1:0]      out_data;
   logic               out_last;
   logic               out_ready;
   logic [1:0]         grant_id;
   logic               busy;
   logic               overrun;
   logic [15:0]        pkt_count;

   typedef struct {logic [7:0] d; logic l;} beat_t;
   typedef struct {int gid; int data; int last;} exp_t;

   beat_t         srcQ[NR][$];
   exp_t          expQ[$];
   logic [NR-1:0] accMask;
   int            cycle;
   int            checks;
   int            failures;

   stream_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .grant_id(grant_id), .busy(busy), .overrun(overrun), .pkt_count(pkt_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cycle = 0;
      forever begin
         @(posedge clk);
         cycle++;
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Source driver: retire beats accepted last cycle, then present each queue head.
   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (accMask[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
            if (srcQ[i].size() > 0) begin
               req_valid[i]          = 1'b1;
               req_data[i*DW +: DW]  = srcQ[i][0].d;
               req_last[i]           = srcQ[i][0].l;
            end else begin
               req_valid[i]          = 1'b0;
               req_data[i*DW +: DW]  = '0;
               req_last[i]           = 1'b0;
            end
         end
      end
   end

   // Monitor: every accepted downstream beat must match the scoreboard head.
   initial begin
      exp_t e;
      accMask = '0;
      forever begin
         @(negedge clk);
         accMask = req_valid & req_ready;
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_beat", int'(out_data), -1);
            end else begin
               e = expQ.pop_front();
               checkOutput("beat_data", int'(out_data), e.data);
               checkOutput("beat_last", int'(out_last), e.last);
               checkOutput("beat_grant", int'(grant_id), e.gid);
            end
         end
      end
   end

   task automatic loadBeat(input int r, input int d, input int l);
      beat_t b;
      b.d = 8'(d);
      b.l = l[0];
      srcQ[r].push_back(b);
   endtask

   task automatic expectBeat(input int g, input int d, input int l);
      exp_t e;
      e.gid  = g;
      e.data = d;
      e.last = l;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input int r, input int d, input int l);
      loadBeat(r, d, l);
      expectBeat(r, d, l);
   endtask

   task automatic flushAll();
      for (int i = 0; i < NR; i++) srcQ[i].delete();
      expQ.delete();
   endtask

   task automatic doReset();
      @(posedge clk);
      #2;
      reset_n   = 1'b0;
      out_ready = 1'b1;
      flushAll();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic waitDrain(input string name);
      for (int c = 0; c < 200 && expQ.size() != 0; c++) @(posedge clk);
      checkOutput(name, expQ.size(), 0);
   endtask

   task automatic waitAccept(input string name);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(out_valid && out_ready) && c < 100);
      checkOutput(name, int'(out_valid && out_ready), 1);
   endtask

   initial begin
      int lastC;
      int got;
      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_req_ready", int'(req_ready), 0);
      checkOutput("rst_pkt_count", int'(pkt_count), 0);
      checkOutput("rst_grant_id", int'(grant_id), 0);
      checkOutput("rst_overrun", int'(overrun), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single 3-beat packet from requester 2
      applyStimulus(2, 8'hA1, 0);
      applyStimulus(2, 8'hA2, 0);
      applyStimulus(2, 8'hA3, 1);
      @(negedge clk);
      checkOutput("single_req_valid", int'(req_valid[2]), 1);
      checkOutput("single_idle_out_valid", int'(out_valid), 0);
      @(negedge clk);
      checkOutput("single_latency_out_valid", int'(out_valid), 1);
      checkOutput("single_grant", int'(grant_id), 2);
      @(negedge clk);
      @(negedge clk);
      checkOutput("single_busy_last", int'(busy), 1);
      @(negedge clk);
      checkOutput("single_busy_after", int'(busy), 0);
      checkOutput("single_pkt_count", int'(pkt_count), 1);
      waitDrain("single_drain");

      // Round-robin fairness with two 1-beat packets per requester
      doReset();
      for (int i = 0; i < NR; i++) begin
         loadBeat(i, 8'h10 + i, 1);
         loadBeat(i, 8'h20 + i, 1);
      end
      for (int i = 0; i < NR; i++) expectBeat(i, 8'h10 + i, 1);
      for (int i = 0; i < NR; i++) expectBeat(i, 8'h20 + i, 1);
      lastC = -1;
      got   = 0;
      for (int c = 0; c < 60 && got < 8; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (got > 0) checkOutput("rr_gap", cycle - lastC, 2);
            lastC = cycle;
            got++;
         end
      end
      checkOutput("rr_count", got, 8);
      @(negedge clk);
      checkOutput("rr_pkt_count", int'(pkt_count), 8);
      waitDrain("rr_drain");

      // Backpressure while beat 2 of a 4-beat packet is presented
      doReset();
      applyStimulus(1, 8'hB1, 0);
      applyStimulus(1, 8'hB2, 0);
      applyStimulus(1, 8'hB3, 0);
      applyStimulus(1, 8'hB4, 1);
      waitAccept("bp_first_beat");
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("bp_req_ready", int'(req_ready[1]), 0);
         checkOutput("bp_hold_data", int'(out_data), 8'hB2);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      waitDrain("bp_drain");

      // Forced release after 16 beats, requester 3 pending
      doReset();
      for (int i = 0; i < 20; i++) loadBeat(0, 8'h40 + i, 0);
      loadBeat(3, 8'hD0, 1);
      for (int i = 0; i < 16; i++) expectBeat(0, 8'h40 + i, 0);
      expectBeat(3, 8'hD0, 1);
      for (int i = 16; i < 20; i++) expectBeat(0, 8'h40 + i, 0);
      for (int b = 0; b < 16; b++) waitAccept("force_beat");
      checkOutput("force_overrun_pre", int'(overrun), 0);
      @(negedge clk);
      checkOutput("force_overrun_pulse", int'(overrun), 1);
      checkOutput("force_pkt_count", int'(pkt_count), 1);
      checkOutput("force_idle", int'(busy), 0);
      @(negedge clk);
      checkOutput("force_overrun_end", int'(overrun), 0);
      checkOutput("force_next_grant", int'(grant_id), 3);
      waitDrain("force_drain");
      checkOutput("force_regrant", int'(grant_id), 0);

      // Asynchronous reset during beat 2 of a 5-beat packet
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(0, 8'h60 + i, (i == 4) ? 1 : 0);
      waitAccept("rstmid_first_beat");
      @(posedge clk);
      #2;
      checkOutput("rstmid_pre_valid", int'(out_valid), 1);
      reset_n = 1'b0;
      flushAll();
      #1;
      checkOutput("rstmid_out_valid", int'(out_valid), 0);
      checkOutput("rstmid_req_ready", int'(req_ready), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("rstmid_pkt_count", int'(pkt_count), 0);
      checkOutput("rstmid_grant_id", int'(grant_id), 0);
      applyStimulus(1, 8'h77, 1);
      @(negedge clk);
      checkOutput("rstmid_idle", int'(out_valid), 0);
      @(negedge clk);
      checkOutput("rstmid_new_valid", int'(out_valid), 1);
      checkOutput("rstmid_new_grant", int'(grant_id), 1);
      waitDrain("rstmid_drain");

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
